// File: rtl/rd_fifo_drain_arb.sv
// Round-robin drain of NUM_SRC show-ahead FIFO read ports into one registered stream.
// A grant is held for a whole burst, ending on a source last beat or after MAX_BURST beats.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no grant; pick the next non-empty source starting at rr_ptr
// ST_LOCK | grant held on r_grant_id; pop when the source has data and the
//         | output register is free or draining
module rd_fifo_drain_arb #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  localparam int ID_W      = $clog2(NUM_SRC)
) (
  input  logic                          rd_clk,
  input  logic                          rd_rstn,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_rdata,
  input  logic [NUM_SRC-1:0]            src_last,
  output logic [NUM_SRC-1:0]            src_rd_en,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [ID_W-1:0]               m_src_id,
  input  logic                          m_ready,
  output logic                          busy
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t                r_state, w_state_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_grant_id;
  logic [BC_W-1:0]       r_beat_cnt;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic [ID_W-1:0]       r_m_src_id;

  logic [DATA_WIDTH-1:0] w_rdata_arr [NUM_SRC];
  logic [ID_W-1:0]       w_pick_id;
  logic                  w_pick_vld;
  logic [ID_W-1:0]       w_grant_inc;
  logic                  w_pop;
  logic                  w_last;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign w_rdata_arr[g] = src_rdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan offsets from highest to lowest so the nearest non-empty source wins.
  always_comb begin
    logic [ID_W:0] v_sum;
    v_sum      = '0;
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      v_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (v_sum >= (ID_W+1)'(NUM_SRC)) v_sum = v_sum - (ID_W+1)'(NUM_SRC);
      if (!src_empty[v_sum[ID_W-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = v_sum[ID_W-1:0];
      end
    end
  end

  assign w_grant_inc = (r_grant_id == ID_W'(NUM_SRC - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_last      = src_last[r_grant_id] | (r_beat_cnt == BC_W'(MAX_BURST - 1));
  assign w_pop       = (r_state == ST_LOCK) & ~src_empty[r_grant_id] & (~r_m_valid | m_ready);

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    src_rd_en   = '0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_vld) w_state_nxt = ST_LOCK;
      end
      ST_LOCK: begin
        busy                  = 1'b1;
        src_rd_en[r_grant_id] = w_pop;
        if (w_pop && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
      r_m_src_id <= '0;
    end else begin
      if (r_state == ST_IDLE && w_pick_vld) begin
        r_grant_id <= w_pick_id;
        r_beat_cnt <= '0;
      end
      if (w_pop) begin
        r_m_valid  <= 1'b1;
        r_m_data   <= w_rdata_arr[r_grant_id];
        r_m_last   <= w_last;
        r_m_src_id <= r_grant_id;
        r_beat_cnt <= r_beat_cnt + 1'b1;
        if (w_last) r_rr_ptr <= w_grant_inc;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_last   = r_m_last;
  assign m_src_id = r_m_src_id;

endmodule

// File: tb/tb_rd_fifo_drain_arb.sv
// Bench for rd_fifo_drain_arb: queue-based FIFO sources, a burst-level arbitration model
// checked every cycle, directed scenarios with literal expectations, and a random soak.
module tb_rd_fifo_drain_arb;

  localparam int NUM_SRC   = 4;
  localparam int DW        = 32;
  localparam int MAX_BURST = 8;
  localparam int ID_W      = 2;

  logic                  rd_clk  = 1'b0;
  logic                  rd_rstn = 1'b0;
  logic [NUM_SRC-1:0]    src_empty = '1;
  logic [NUM_SRC*DW-1:0] src_rdata = '0;
  logic [NUM_SRC-1:0]    src_last  = '0;
  logic [NUM_SRC-1:0]    src_rd_en;
  logic                  m_valid;
  logic [DW-1:0]         m_data;
  logic                  m_last;
  logic [ID_W-1:0]       m_src_id;
  logic                  m_ready = 1'b1;
  logic                  busy;

  rd_fifo_drain_arb #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .src_empty(src_empty), .src_rdata(src_rdata),
    .src_last(src_last), .src_rd_en(src_rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_src_id(m_src_id), .m_ready(m_ready), .busy(busy)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct { logic [DW-1:0] data; bit last; } beat_t;
  typedef struct { int id; logic [DW-1:0] data; bit last; int cyc; } rec_t;

  beat_t              fq   [NUM_SRC][$];
  logic [DW-1:0]      sent [NUM_SRC][$];
  rec_t               log_q[$];
  logic [NUM_SRC-1:0] hold = '0;
  int                 ser  [NUM_SRC];
  int n_tests = 0, n_fail = 0, cyc = 0;

  // Model: owner = source holding the burst (-1 = none), plus the expected output register.
  int            mo_owner = -1, mo_next = 0, mo_cnt = 0, mo_id = 0;
  bit            mo_valid = 1'b0, mo_last = 1'b0;
  logic [DW-1:0] mo_data  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge rd_clk);
    #2;
  endtask

  task automatic push_burst(input int s, input int n, input bit last_end, input bit rnd_mid);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data = {8'(s), 8'(ser[s]), 16'($urandom)};
      ser[s]++;
      b.last = (k == n - 1) ? last_end : (rnd_mid && ($urandom % 6 == 0));
      fq[s].push_back(b);
      sent[s].push_back(b.data);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      cycles(1);
      done = !m_valid && !busy;
      for (int s = 0; s < NUM_SRC; s++) if (fq[s].size() != 0) done = 1'b0;
    end
    check("drain_done", 64'(done), 64'(1));
  endtask

  task automatic verify_log();
    foreach (log_q[i]) begin
      if (sent[log_q[i].id].size() == 0) check("sb_extra_beat", 64'(log_q[i].id), 64'(NUM_SRC));
      else check("sb_data", 64'(log_q[i].data), 64'(sent[log_q[i].id].pop_front()));
    end
    for (int s = 0; s < NUM_SRC; s++) check("sb_missing", 64'(sent[s].size()), 64'(0));
  endtask

  // FIFO emulation, reference model and per-cycle compare.
  initial begin : cmp
    logic [NUM_SRC-1:0] avail;
    logic [NUM_SRC-1:0] exp_en;
    bit                 pop_e;
    forever begin
      @(negedge rd_clk);
      for (int i = 0; i < NUM_SRC; i++) begin
        avail[i] = (fq[i].size() > 0) && !hold[i];
        src_empty[i] = !avail[i];
        src_rdata[i*DW +: DW] = avail[i] ? fq[i][0].data : '0;
        src_last[i] = avail[i] && fq[i][0].last;
      end
      #1;
      cyc++;
      if (!rd_rstn) begin
        check("rst_rd_en", 64'(src_rd_en), 64'(0));
        check("rst_valid", 64'(m_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_data", 64'(m_data), 64'(0));
        check("rst_last", 64'(m_last), 64'(0));
        check("rst_id", 64'(m_src_id), 64'(0));
        mo_owner = -1; mo_next = 0; mo_cnt = 0; mo_id = 0;
        mo_valid = 1'b0; mo_last = 1'b0; mo_data = '0;
      end else begin
        pop_e  = (mo_owner >= 0) && avail[mo_owner] && (!mo_valid || m_ready);
        exp_en = pop_e ? (NUM_SRC'(1) << mo_owner) : '0;
        check("rd_en", 64'(src_rd_en), 64'(exp_en));
        check("busy", 64'(busy), 64'(mo_owner >= 0));
        check("m_valid", 64'(m_valid), 64'(mo_valid));
        check("m_data", 64'(m_data), 64'(mo_data));
        check("m_last", 64'(m_last), 64'(mo_last));
        check("m_src_id", 64'(m_src_id), 64'(mo_id));
        if (m_valid && m_ready) log_q.push_back('{int'(m_src_id), m_data, m_last, cyc});
        if (mo_owner >= 0) begin
          if (pop_e) begin
            mo_valid = 1'b1;
            mo_data  = fq[mo_owner][0].data;
            mo_id    = mo_owner;
            mo_cnt++;
            mo_last  = fq[mo_owner][0].last || (mo_cnt == MAX_BURST);
            if (mo_last) begin
              mo_next  = (mo_owner + 1) % NUM_SRC;
              mo_owner = -1;
            end
          end else if (mo_valid && m_ready) begin
            mo_valid = 1'b0;
          end
        end else begin
          if (mo_valid && m_ready) mo_valid = 1'b0;
          for (int k = 0; k < NUM_SRC; k++)
            if (mo_owner < 0 && avail[(mo_next + k) % NUM_SRC]) begin
              mo_owner = (mo_next + k) % NUM_SRC;
              mo_cnt   = 0;
            end
        end
        for (int i = 0; i < NUM_SRC; i++)
          if (src_rd_en[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e2 [$];
    int e4 [$];
    int e5 [$];
    logic [DW-1:0] held_b2;
    e2 = '{0,0,0,1,1,1,1,1,1,1,1,3,3,3,1,1,1,1,1,1,1,1,1,1,1,1};
    e4 = '{2,2,2,2,2,3,3};
    e5 = '{1,0,1,1,3};

    // Reset with every source non-empty, then round-robin over 2-beat bursts.
    for (int s = 0; s < NUM_SRC; s++) push_burst(s, 2, 1'b1, 1'b0);
    cycles(3);
    log_q.delete();
    rd_rstn = 1'b1;
    @(negedge rd_clk); #2;
    check("t1_c0_busy", 64'(busy), 64'(0));
    @(negedge rd_clk); #2;
    check("t1_c1_busy", 64'(busy), 64'(1));
    check("t1_c1_valid", 64'(m_valid), 64'(0));
    @(negedge rd_clk); #2;
    check("t1_c2_valid", 64'(m_valid), 64'(1));
    check("t1_c2_id", 64'(m_src_id), 64'(0));
    wait_idle(100);
    check("t1_len", 64'(log_q.size()), 64'(8));
    foreach (log_q[i]) begin
      check("t1_order", 64'(log_q[i].id), 64'(i / 2));
      if (i > 0) check("t1_gap", 64'(log_q[i].cyc - log_q[i-1].cyc), 64'((i % 2 == 0) ? 2 : 1));
    end
    verify_log();

    // Forced release: source 1 carries 20 beats with a last only on the final one.
    log_q.delete();
    push_burst(0, 3, 1'b1, 1'b0);
    push_burst(1, 20, 1'b1, 1'b0);
    push_burst(3, 3, 1'b1, 1'b0);
    wait_idle(200);
    check("t2_len", 64'(log_q.size()), 64'(e2.size()));
    foreach (log_q[i]) if (i < e2.size()) begin
      check("t2_order", 64'(log_q[i].id), 64'(e2[i]));
      check("t2_last", 64'(log_q[i].last), 64'(i == 2 || i == 10 || i == 13 || i == 21 || i == 25));
    end
    verify_log();

    // Backpressure mid-burst.
    log_q.delete();
    push_burst(2, 6, 1'b1, 1'b0);
    cycles(4);
    m_ready = 1'b0;
    held_b2 = m_data;
    cycles(2);
    check("t3_stall_rd_en", 64'(src_rd_en), 64'(0));
    check("t3_stall_valid", 64'(m_valid), 64'(1));
    check("t3_stall_data", 64'(m_data), 64'(held_b2));
    check("t3_stall_beat", 64'(m_data), 64'(sent[2][2]));
    cycles(3);
    m_ready = 1'b1;
    wait_idle(100);
    check("t3_len", 64'(log_q.size()), 64'(6));
    verify_log();

    // Source empties mid-burst while another source requests.
    log_q.delete();
    push_burst(2, 3, 1'b0, 1'b0);
    cycles(6);
    push_burst(3, 2, 1'b1, 1'b0);
    cycles(10);
    check("t4_hold_busy", 64'(busy), 64'(1));
    check("t4_hold_rd_en", 64'(src_rd_en), 64'(0));
    check("t4_hold_id", 64'(m_src_id), 64'(2));
    push_burst(2, 2, 1'b1, 1'b0);
    wait_idle(100);
    check("t4_len", 64'(log_q.size()), 64'(e4.size()));
    foreach (log_q[i]) if (i < e4.size()) check("t4_order", 64'(log_q[i].id), 64'(e4[i]));
    verify_log();

    // Reset on beat 2 of a 4-beat burst; that beat is lost and rotation restarts at 0.
    log_q.delete();
    push_burst(1, 4, 1'b1, 1'b0);
    cycles(3);
    check("t5_pre_valid", 64'(m_valid), 64'(1));
    check("t5_pre_data", 64'(m_data), 64'(sent[1][1]));
    rd_rstn = 1'b0;
    #1;
    check("t5_rst_valid", 64'(m_valid), 64'(0));
    check("t5_rst_rd_en", 64'(src_rd_en), 64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    sent[1].delete(1);
    push_burst(0, 1, 1'b1, 1'b0);
    push_burst(3, 1, 1'b1, 1'b0);
    cycles(2);
    rd_rstn = 1'b1;
    wait_idle(100);
    check("t5_len", 64'(log_q.size()), 64'(e5.size()));
    foreach (log_q[i]) if (i < e5.size()) check("t5_order", 64'(log_q[i].id), 64'(e5[i]));
    verify_log();

    // Random soak: bursts of 1..20 beats, random backpressure and empty gaps.
    log_q.delete();
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 12 == 0) push_burst(int'($urandom % NUM_SRC), 1 + int'($urandom % 20), 1'b1, 1'b1);
      m_ready = ($urandom % 4) != 0;
      if ($urandom % 16 == 0) hold[$urandom % NUM_SRC] ^= 1'b1;
      cycles(1);
    end
    hold    = '0;
    m_ready = 1'b1;
    wait_idle(5000);
    verify_log();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
